// File: rtl/npu_conv_sequencer.sv
// Convolution layer sequencer: accepts feature beats, issues them to the MAC core,
// and times accumulator restarts and clipped-output strobes with a tag shift pipeline.
module npu_conv_sequencer #(
  parameter int MAC_OUT_NUM = 18,
  parameter int ARRAY_LAT   = 12,
  parameter int ACC_W       = 8,
  parameter int PIX_W       = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ACC_W-1:0]       cfg_accum_num,
  input  logic [PIX_W-1:0]       cfg_pix_num,
  input  logic [15:0]            cfg_scale,
  input  logic                   fm_valid,
  output logic                   fm_ready,
  output logic                   mac_data_valid,
  output logic                   mac_weight_valid,
  output logic [ACC_W-1:0]       weight_addr,
  output logic [15:0]            mac_scale,
  output logic [MAC_OUT_NUM-1:0] adder_rst,
  output logic                   out_valid,
  output logic [PIX_W-1:0]       out_pix_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE
  } state_t;

  // One tag per issued beat; it rides alongside the beat through the core latency.
  typedef struct packed {
    logic             first;
    logic             last;
    logic             fin;
    logic [PIX_W-1:0] pix;
  } tag_t;

  localparam int DEPTH   = ARRAY_LAT + 5;
  localparam int RST_TAP = ARRAY_LAT;
  localparam int OUT_TAP = ARRAY_LAT + 4;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] accum_q, acc_cnt;
  logic [PIX_W-1:0] pix_q, pix_cnt;
  logic             hs, issue, cfg_ok, start_ok, beat_last, beat_fin;
  tag_t             beat_tag;
  tag_t             pipe [DEPTH];

  assign fm_ready  = (state == S_RUN);
  assign hs        = fm_valid & fm_ready;
  assign issue     = hs & ~abort;
  assign cfg_ok    = (cfg_accum_num != '0) && (cfg_pix_num != '0);
  assign start_ok  = start & ~abort & (state == S_IDLE) & cfg_ok;
  assign beat_last = (acc_cnt == accum_q - ACC_W'(1));
  assign beat_fin  = beat_last && (pix_cnt == pix_q - PIX_W'(1));

  always_comb begin
    beat_tag       = '0;
    beat_tag.first = (acc_cnt == '0);
    beat_tag.last  = beat_last;
    beat_tag.fin   = beat_fin;
    beat_tag.pix   = pix_cnt;
  end

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   if (hs && beat_fin) state_nxt = S_DRAIN;
      S_DRAIN: if (pipe[OUT_TAP].fin) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      accum_q        <= '0;
      pix_q          <= '0;
      mac_scale      <= '0;
      acc_cnt        <= '0;
      pix_cnt        <= '0;
      mac_data_valid <= 1'b0;
      weight_addr    <= '0;
      cfg_err        <= 1'b0;
    end else begin
      cfg_err <= start & ~abort & (state == S_IDLE) & ~cfg_ok;
      if (start_ok) begin
        accum_q   <= cfg_accum_num;
        pix_q     <= cfg_pix_num;
        mac_scale <= cfg_scale;
      end
      if (abort || state == S_LOAD) begin
        acc_cnt <= '0;
        pix_cnt <= '0;
      end else if (hs) begin
        acc_cnt <= beat_last ? '0 : acc_cnt + ACC_W'(1);
        if (beat_last) pix_cnt <= pix_cnt + PIX_W'(1);
      end
      mac_data_valid <= issue;
      if (issue) weight_addr <= acc_cnt;
    end
  end

  // NOTE: the tag pipeline carries control, not data, so every stage is reset;
  // leaving it unreset would let stale tags fire out_valid after rstn rises.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= issue ? beat_tag : '0;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= abort ? '0 : pipe[i-1];
    end
  end

  assign mac_weight_valid = mac_data_valid;
  assign adder_rst        = {MAC_OUT_NUM{pipe[RST_TAP].first}};
  assign out_valid        = pipe[OUT_TAP].last;
  assign out_pix_idx      = out_valid ? pipe[OUT_TAP].pix : '0;
  assign busy             = (state != S_IDLE);
  assign done             = (state == S_DONE);

endmodule

// File: tb/tb_npu_conv_sequencer.sv
// Self-checking bench: each layer's expected output timeline is planned from a list
// of accepted beats, then compared cycle by cycle against the sequencer.
module tb_npu_conv_sequencer;

  localparam int L    = 12;
  localparam int NOUT = 18;
  localparam int AW   = 8;
  localparam int PW   = 16;
  localparam int MAXS = 512;

  logic            clk, rstn, start, abort, fm_valid;
  logic [AW-1:0]   cfg_accum_num;
  logic [PW-1:0]   cfg_pix_num;
  logic [15:0]     cfg_scale;
  logic            fm_ready, mac_data_valid, mac_weight_valid;
  logic [AW-1:0]   weight_addr;
  logic [15:0]     mac_scale;
  logic [NOUT-1:0] adder_rst;
  logic            out_valid, busy, done, cfg_err;
  logic [PW-1:0]   out_pix_idx;

  npu_conv_sequencer #(
    .MAC_OUT_NUM(NOUT), .ARRAY_LAT(L), .ACC_W(AW), .PIX_W(PW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_accum_num(cfg_accum_num), .cfg_pix_num(cfg_pix_num), .cfg_scale(cfg_scale),
    .fm_valid(fm_valid), .fm_ready(fm_ready), .mac_data_valid(mac_data_valid),
    .mac_weight_valid(mac_weight_valid), .weight_addr(weight_addr), .mac_scale(mac_scale),
    .adder_rst(adder_rst), .out_valid(out_valid), .out_pix_idx(out_pix_idx),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cur_scale = 0;

  int e_ready [MAXS];
  int e_mdv   [MAXS];
  int e_addr  [MAXS];
  int e_arst  [MAXS];
  int e_ov    [MAXS];
  int e_idx   [MAXS];
  int e_busy  [MAXS];
  int e_done  [MAXS];
  int e_scale [MAXS];
  bit v       [MAXS];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ":fm_ready"}, 32'(fm_ready), 0);
    check({tag, ":mdv"}, 32'(mac_data_valid), 0);
    check({tag, ":mwv"}, 32'(mac_weight_valid), 0);
    check({tag, ":adder_rst"}, 32'(adder_rst), 0);
    check({tag, ":out_valid"}, 32'(out_valid), 0);
    check({tag, ":busy"}, 32'(busy), 0);
    check({tag, ":done"}, 32'(done), 0);
    check({tag, ":cfg_err"}, 32'(cfg_err), 0);
    check({tag, ":mac_scale"}, 32'(mac_scale), 32'(cur_scale));
  endtask

  // mode: 0 = fm_valid always high, 1 = random, 2 = one beat then a 2-cycle hole.
  // abort_at / busy_start_at: sample after which the pulse is driven (-1 = none).
  // rst_mode: pulse rstn low for one cycle while draining.
  task automatic run_layer(input int accum, input int pix, input int scale, input int mode,
                           input int abort_at, input int rst_mode, input int busy_start_at);
    int k, jl, done_s, last_s, trunc, rst_at, nbeats;
    logic [NOUT-1:0] ones;
    string t;
    ones   = '1;
    nbeats = accum * pix;
    for (int s = 0; s < MAXS; s++) begin
      e_ready[s] = 0; e_mdv[s] = 0; e_addr[s] = 0; e_arst[s] = 0; e_ov[s] = 0;
      e_idx[s] = 0; e_busy[s] = 0; e_done[s] = 0; e_scale[s] = scale;
      case (mode)
        0:       v[s] = 1'b1;
        2:       v[s] = !(s == 3 || s == 4);
        default: v[s] = ($urandom_range(0, 3) != 0);
      endcase
    end
    // Beats are accepted from edge 2 (first cycle in RUN) on every fm_valid edge.
    k  = 0;
    jl = 2;
    for (int j = 2; j < MAXS - 40 && k < nbeats; j++) begin
      if (v[j]) begin
        e_mdv[j]  = 1;
        e_addr[j] = k % accum;
        if (k % accum == 0) e_arst[j + L] = 1;
        if (k % accum == accum - 1) begin
          e_ov[j + L + 4]  = 1;
          e_idx[j + L + 4] = k / accum;
        end
        jl = j;
        k++;
      end
    end
    done_s = jl + L + 5;
    for (int s = 0; s <= done_s; s++) e_busy[s] = 1;
    for (int s = 1; s < jl; s++) e_ready[s] = 1;
    e_done[done_s] = 1;
    last_s = done_s + 3;
    trunc  = MAXS;
    rst_at = -1;
    if (abort_at >= 0) trunc = abort_at + 1;
    if (rst_mode != 0) begin
      rst_at = jl + 3;
      trunc  = rst_at + 1;
    end
    if (trunc < MAXS) begin
      for (int s = trunc; s < MAXS; s++) begin
        e_ready[s] = 0; e_mdv[s] = 0; e_arst[s] = 0; e_ov[s] = 0;
        e_busy[s] = 0; e_done[s] = 0;
        if (rst_mode != 0) e_scale[s] = 0;
      end
      last_s = trunc + L + 8;
    end

    start = 1'b1; abort = 1'b0; fm_valid = v[0];
    cfg_accum_num = AW'(accum); cfg_pix_num = PW'(pix); cfg_scale = 16'(scale);
    for (int s = 0; s <= last_s; s++) begin
      @(negedge clk);
      t = $sformatf("a%0d_p%0d@%0d", accum, pix, s);
      check({t, ":fm_ready"}, 32'(fm_ready), 32'(e_ready[s]));
      check({t, ":mdv"}, 32'(mac_data_valid), 32'(e_mdv[s]));
      check({t, ":mwv"}, 32'(mac_weight_valid), 32'(e_mdv[s]));
      if (e_mdv[s] != 0) check({t, ":waddr"}, 32'(weight_addr), 32'(e_addr[s]));
      check({t, ":adder_rst"}, 32'(adder_rst), (e_arst[s] != 0) ? 32'(ones) : 32'd0);
      check({t, ":out_valid"}, 32'(out_valid), 32'(e_ov[s]));
      if (e_ov[s] != 0) check({t, ":pix_idx"}, 32'(out_pix_idx), 32'(e_idx[s]));
      check({t, ":busy"}, 32'(busy), 32'(e_busy[s]));
      check({t, ":done"}, 32'(done), 32'(e_done[s]));
      check({t, ":cfg_err"}, 32'(cfg_err), 0);
      check({t, ":mac_scale"}, 32'(mac_scale), 32'(e_scale[s]));
      if (s == rst_at + 1 && rst_at >= 0) begin
        check({t, ":rst_waddr"}, 32'(weight_addr), 0);
        check({t, ":rst_idx"}, 32'(out_pix_idx), 0);
      end
      start    = (s == busy_start_at);
      if (s == busy_start_at) begin
        cfg_accum_num = '0;
        cfg_scale     = 16'hdead;
      end
      fm_valid = v[s + 1];
      abort    = (s == abort_at);
      if (s == rst_at) rstn = 1'b0;
      if (s == rst_at + 1 && rst_at >= 0) rstn = 1'b1;
    end
    cur_scale = e_scale[last_s];
    start = 1'b0; abort = 1'b0; fm_valid = 1'b0;
  endtask

  task automatic bad_cfg(input int accum, input int pix);
    start = 1'b1;
    cfg_accum_num = AW'(accum); cfg_pix_num = PW'(pix); cfg_scale = 16'h0777;
    @(negedge clk);
    start = 1'b0;
    check("cfg_err:pulse", 32'(cfg_err), 1);
    check("cfg_err:busy", 32'(busy), 0);
    check("cfg_err:scale", 32'(mac_scale), 32'(cur_scale));
    @(negedge clk);
    check("cfg_err:single", 32'(cfg_err), 0);
    check("cfg_err:busy2", 32'(busy), 0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; fm_valid = 1'b0;
    cfg_accum_num = '0; cfg_pix_num = '0; cfg_scale = '0;
    @(negedge clk);
    check_quiet("reset");
    check("reset:waddr", 32'(weight_addr), 0);
    check("reset:idx", 32'(out_pix_idx), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_quiet("idle");

    run_layer(9, 2, 16'h1234, 0, -1, 0, -1);
    run_layer(1, 4, 16'h0005, 0, -1, 0, -1);
    run_layer(3, 1, 16'h00a0, 2, -1, 0, -1);
    bad_cfg(0, 3);
    bad_cfg(4, 0);
    run_layer(9, 2, 16'h4321, 0, 6, 0, -1);
    run_layer(9, 2, 16'h0042, 0, -1, 0, -1);
    run_layer(2, 3, 16'h0011, 0, -1, 0, 5);
    for (int i = 0; i < 4; i++) begin
      run_layer(int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
                int'($urandom & 32'hffff), 1, -1, 0, -1);
    end
    run_layer(2, 2, 16'h0bad, 0, -1, 1, -1);
    @(negedge clk);
    check_quiet("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npu_conv_sequencer.md
NPU_CONV_SEQUENCER -- requirements
Module: npu_conv_sequencer

Interface
REQ-001 SHALL have parameter MAC_OUT_NUM, default 18, meaning the width of the adder_rst vector (one bit per MAC output).
REQ-002 SHALL have parameter ARRAY_LAT, default 12, meaning cycles from a data beat issued on mac_data_valid to its product at the accumulator input.
REQ-003 SHALL have parameter ACC_W, default 8, meaning the width of the accumulation count and of weight_addr.
REQ-004 SHALL have parameter PIX_W, default 16, meaning the width of the pixel count.
REQ-005 SHALL have ports, one per line, as name, direction, width, meaning:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle layer start pulse
- abort  in  1  synchronous soft clear
- cfg_accum_num  in  ACC_W  beats per output pixel
- cfg_pix_num  in  PIX_W  output pixels per layer
- cfg_scale  in  16  right-shift amount for the core
- fm_valid  in  1  feature beat available
- fm_ready  out  1  feature beat accepted
- mac_data_valid  out  1  beat presented to the core
- mac_weight_valid  out  1  weights valid for the core
- weight_addr  out  ACC_W  weight-buffer index of the current beat
- mac_scale  out  16  latched cfg_scale
- adder_rst  out  MAC_OUT_NUM  accumulator restart, all bits identical
- out_valid  out  1  clipped core output valid
- out_pix_idx  out  PIX_W  pixel index of out_valid
- busy  out  1  not IDLE
- done  out  1  single-cycle completion pulse
- cfg_err  out  1  single-cycle illegal-config pulse

Function
REQ-006 SHALL implement states IDLE, LOAD, RUN, DRAIN and DONE.
REQ-007 In IDLE, start with cfg_accum_num!=0 and cfg_pix_num!=0 SHALL latch all cfg_* values and go to LOAD; otherwise start SHALL pulse cfg_err and remain in IDLE.
REQ-008 LOAD SHALL last 1 cycle, clear acc_cnt and pix_cnt, and go to RUN.
REQ-009 In RUN, fm_ready SHALL be 1; in all other states it SHALL be 0.
REQ-010 Each beat with fm_valid&fm_ready SHALL register mac_data_valid=1, mac_weight_valid=1 and weight_addr=acc_cnt on the next cycle.
REQ-011 Cycles without a handshake SHALL register mac_data_valid=0; the core contributes zero on such cycles.
REQ-012 acc_cnt SHALL increment per beat and wrap to 0 after cfg_accum_num-1; each wrap SHALL increment pix_cnt.
REQ-013 The first beat of each pixel (acc_cnt==0) SHALL drive adder_rst to all ones exactly ARRAY_LAT cycles after that beat's mac_data_valid; otherwise adder_rst SHALL be all zeros.
REQ-014 The last beat of each pixel SHALL produce out_valid=1 with out_pix_idx=pixel index exactly ARRAY_LAT+4 cycles after its mac_data_valid (1 accumulate, 3 scale/clip stages).
REQ-015 The adder_rst and out_valid timing SHALL use a tag shift pipeline, so that back-to-back pixels with cfg_accum_num=1 assert adder_rst and out_valid on consecutive cycles.
REQ-016 After the last beat of pixel cfg_pix_num-1, the block SHALL go to DRAIN and stay there until the final out_valid has been emitted.
REQ-017 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 start while busy SHALL be ignored, with no cfg_err.
REQ-020 abort SHALL return the block to IDLE on the next cycle, clear the counters and the tag pipeline, suppress done, and take priority over start.
REQ-021 mac_scale SHALL hold the latched cfg_scale until the next accepted start.

Reset
REQ-022 While rstn is low, the block SHALL be in IDLE with fm_ready, mac_data_valid, mac_weight_valid, out_valid, busy, done and cfg_err at 0, and with adder_rst, weight_addr, out_pix_idx and mac_scale at 0.
REQ-023 Reset asserted mid-layer SHALL discard all in-flight tags, so that no out_valid or done is produced after rstn deasserts.

Verification
REQ-024 accum=9, pix=2, fm_valid held high -> beats at weight_addr 0..8 twice; adder_rst at issue+12 for beats 0 and 9; out_valid at issue+16 for beats 8 and 17, with idx 0 and 1; done one cycle after the last out_valid.
REQ-025 accum=1, pix=4 -> adder_rst and out_valid each high for 4 consecutive cycles, with idx 0,1,2,3.
REQ-026 accum=3, pix=1, fm_valid low for 2 cycles after the first beat -> mac_data_valid gaps of 2 cycles; out_valid at 16 cycles after the third beat.
REQ-027 start with cfg_accum_num=0 -> cfg_err pulse, busy stays 0.
REQ-028 abort during RUN, then start again -> no stale out_valid; the new layer's timing is per REQ-024.
REQ-029 rstn low for 1 cycle in DRAIN -> all outputs 0, and no out_valid or done afterwards.
